// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the 8N1 UART transmitter/receiver pair.
package uart_pkg;

  // 50 MHz system clock at 115200 baud.
  localparam int unsigned BAUD_DIV_DEFAULT = 434;

  // Character width of one frame (8N1).
  localparam int unsigned DATA_W = 8;

  // Baud counter width; covers the full legal divider range up to 65535.
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver. Synchronizes the pin, validates the start bit at half a bit,
// samples data and stop at bit centres, and publishes only correctly framed bytes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              rx,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_W - 1);

  rx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              rx_meta, rx_sync;

  // Two-flop synchronizer for the asynchronous pin, reset to the idle line level
  // so leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= RX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      rx_data  <= data_nxt;
      rx_valid <= valid_nxt;
    end
  end

  // Sampling sequence: start check at half a bit, then one sample per bit period.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    data_nxt     = rx_data;
    valid_nxt    = 1'b0;

    case (state)
      RX_IDLE: begin
        baud_cnt_nxt = '0;
        if (!rx_sync) begin
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        baud_cnt_nxt = baud_cnt + 1'b1;
        if (baud_cnt == HALF_LAST) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          // A line already back high at mid-start is noise, not a frame.
          state_nxt    = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        baud_cnt_nxt = baud_cnt + 1'b1;
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_nxt = '0;
          shift_nxt    = {rx_sync, shift[DATA_W-1:1]};
          bit_idx_nxt  = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) begin
            state_nxt = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        baud_cnt_nxt = baud_cnt + 1'b1;
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_nxt = '0;
          // Framing error leaves rx_data untouched and raises no pulse.
          if (rx_sync) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end
          // Re-arm at mid-stop so a back-to-back start edge is not missed.
          state_nxt = RX_IDLE;
        end
      end
      default: begin
        state_nxt = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter. Accepts one byte while idle and shifts it out LSB first,
// each bit lasting exactly BAUD_DIV clocks. Requests made while busy are dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              tx_busy,
  output logic              tx
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_W - 1);

  tx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              tx_nxt;
  logic              busy_nxt;
  logic              bit_done;

  assign bit_done = (baud_cnt == BIT_LAST);

  // State and datapath registers; tx idles high and is forced high by reset.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      tx_busy  <= busy_nxt;
    end
  end

  // Next-state and next-output logic; tx/tx_busy are computed one cycle ahead so
  // the pin changes on the very edge that starts each bit.
  // NOTE: every signal gets a hold-value default first, so no path through the
  // case statement leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    tx_nxt       = tx;
    busy_nxt     = tx_busy;

    if (state != TX_IDLE) begin
      baud_cnt_nxt = bit_done ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      TX_IDLE: begin
        if (wr_en) begin
          shift_nxt    = wr_data;
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) begin
          tx_nxt    = shift[0];
          state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          if (bit_idx == IDX_LAST) begin
            tx_nxt    = 1'b1;
            state_nxt = TX_STOP;
          end else begin
            shift_nxt   = {1'b1, shift[DATA_W-1:1]};
            tx_nxt      = shift[1];
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = TX_IDLE;
        end
      end
      default: begin
        state_nxt = TX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_txrx_top.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock.
module uart_txrx_top
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              tx_busy,
  output logic              tx,
  input  logic              rx,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data
);

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk     (clk),
    .rstb    (rstb),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .tx_busy (tx_busy),
    .tx      (tx)
  );

  uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk      (clk),
    .rstb     (rstb),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

endmodule

// File: tb/tb_uart_txrx_top.sv
// Scoreboard bench for uart_txrx_top: a BAUD_DIV=16 instance for the main scenarios
// and a BAUD_DIV=4 instance for the minimum-divider boundary, both in loopback.
`timescale 1ns/1ps
module tb_uart_txrx_top;

  localparam int unsigned B  = 16;
  localparam int unsigned B4 = 4;

  logic       clk = 1'b0;
  logic       rstb;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_busy;
  logic       tx;
  logic       rx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       loop_en;
  logic       rx_drv;

  logic       wr_en4;
  logic [7:0] wr_data4;
  logic       tx_busy4;
  logic       tx4;
  logic       rx_valid4;
  logic [7:0] rx_data4;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_count  = 0;
  int rx_count4 = 0;
  int n_sent  = 0;
  int n_sent4 = 0;
  int cnt0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_q4[$];
  logic [7:0] exp_b;
  logic [7:0] exp_b4;
  logic [7:0] rnd_b;
  logic [9:0] frame;

  always #5 clk = ~clk;

  assign rx = loop_en ? tx : rx_drv;

  uart_txrx_top #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_busy  (tx_busy),
    .tx       (tx),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  uart_txrx_top #(.BAUD_DIV(B4)) dut4 (
    .clk      (clk),
    .rstb     (rstb),
    .wr_en    (wr_en4),
    .wr_data  (wr_data4),
    .tx_busy  (tx_busy4),
    .tx       (tx4),
    .rx       (tx4),
    .rx_valid (rx_valid4),
    .rx_data  (rx_data4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the main instance: every rx_valid pops one expected byte.
  always @(negedge clk) begin
    if (rstb && rx_valid) begin
      rx_count++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%02h, expected no byte", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        check("rx_byte", 32'(rx_data), 32'(exp_b));
      end
    end
  end

  // Monitor for the BAUD_DIV=4 instance.
  always @(negedge clk) begin
    if (rstb && rx_valid4) begin
      rx_count4++;
      if (exp_q4.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx4_unexpected: got 0x%02h, expected no byte", rx_data4);
      end else begin
        exp_b4 = exp_q4.pop_front();
        check("rx4_byte", 32'(rx_data4), 32'(exp_b4));
      end
    end
  end

  // Waits for the transmitter to be free, then issues a one-cycle request.
  // Returns on the falling edge just after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, input bit expect_rx);
    int n = 0;
    @(negedge clk);
    while (tx_busy && n < int'(40 * B)) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(tx_busy), 32'd0);
    wr_data = b;
    wr_en   = 1'b1;
    if (expect_rx) begin
      exp_q.push_back(b);
      n_sent++;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic send_byte4(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (tx_busy4 && n < int'(40 * B4)) begin
      @(negedge clk);
      n++;
    end
    check("send4_ready", 32'(tx_busy4), 32'd0);
    wr_data4 = b;
    wr_en4   = 1'b1;
    exp_q4.push_back(b);
    n_sent4++;
    @(negedge clk);
    wr_en4 = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < int'(20 * B)) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic drain4(input string name);
    int n = 0;
    while (exp_q4.size() != 0 && n < int'(20 * B4)) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q4.size()), 32'd0);
  endtask

  // Global time bound.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] a5_frame;
    rstb     = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    wr_en4   = 1'b0;
    wr_data4 = 8'h00;
    loop_en  = 1'b1;
    rx_drv   = 1'b1;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst4_tx", 32'(tx4), 32'd1);
    check("rst4_rx_data", 32'(rx_data4), 32'h00);
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    // Loopback 0xA5: pin pattern 0,1,0,1,0,0,1,0,1,1 and exact busy duration.
    a5_frame = 10'b1101001010;
    send_byte(8'hA5, 1'b1);
    check("a5_busy_at_accept", 32'(tx_busy), 32'd1);
    for (int k = 0; k < 10; k++) begin
      repeat (B / 2) @(posedge clk);
      #1;
      check($sformatf("a5_bit%0d", k), 32'(tx), 32'(a5_frame[k]));
      if (k == 9) begin
        repeat (B - B / 2 - 1) @(posedge clk);
        #1;
        check("a5_busy_last_cycle", 32'(tx_busy), 32'd1);
        @(posedge clk);
        #1;
        check("a5_busy_released", 32'(tx_busy), 32'd0);
        check("a5_tx_idle", 32'(tx), 32'd1);
      end else begin
        repeat (B - B / 2) @(posedge clk);
      end
    end
    drain("a5_drain");
    check("a5_rx_data", 32'(rx_data), 32'hA5);

    // Back-to-back random traffic.
    for (int i = 0; i < 200; i++) begin
      rnd_b = 8'($urandom_range(0, 255));
      send_byte(rnd_b, 1'b1);
    end
    drain("random_drain");

    // Write while busy: 0x3C mid-frame of 0x81 must be dropped.
    send_byte(8'h81, 1'b1);
    repeat (3 * B) @(negedge clk);
    wr_data = 8'h3C;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("busy_during_write", 32'(tx_busy), 32'd1);
    drain("busy_drain");
    repeat (12 * B) @(negedge clk);
    check("busy_rx_data", 32'(rx_data), 32'h81);
    check("busy_tx_idle", 32'(tx_busy), 32'd0);

    // Glitch shorter than half a bit: no byte.
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (2 * B) @(negedge clk);
    cnt0   = rx_count;
    rx_drv = 1'b0;
    repeat (B / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * B) @(negedge clk);
    check("glitch_no_valid", 32'(rx_count), 32'(cnt0));

    // 0x55 with a low stop bit. The stop bit stays low past its centre, then is
    // released early so the trailing low is rejected as a glitch on re-arm.
    frame = {1'b0, 8'h55, 1'b0};
    for (int k = 0; k < 9; k++) begin
      rx_drv = frame[k];
      repeat (B) @(negedge clk);
    end
    rx_drv = frame[9];
    repeat (3 * B / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * B) @(negedge clk);
    check("framing_no_valid", 32'(rx_count), 32'(cnt0));
    check("framing_rx_data_held", 32'(rx_data), 32'h81);
    loop_en = 1'b1;
    repeat (2 * B) @(negedge clk);

    // Reset during data bit 3 of 0x5A: outputs return to idle at once.
    send_byte(8'h5A, 1'b0);
    repeat (4 * B + B / 2) @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_tx_busy", 32'(tx_busy), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'hF0, 1'b1);
    drain("f0_drain");
    check("f0_rx_data", 32'(rx_data), 32'hF0);

    // Minimum divider: all-zero and all-one payloads, plus a mixed byte.
    send_byte4(8'h00);
    drain4("b4_00_drain");
    check("b4_00_rx_data", 32'(rx_data4), 32'h00);
    send_byte4(8'hFF);
    drain4("b4_ff_drain");
    check("b4_ff_rx_data", 32'(rx_data4), 32'hFF);
    send_byte4(8'h5A);
    drain4("b4_5a_drain");
    repeat (12 * B4) @(negedge clk);

    // Totals: nothing lost, nothing extra.
    repeat (4 * B) @(negedge clk);
    check("rx_count_total", 32'(rx_count), 32'(n_sent));
    check("rx4_count_total", 32'(rx_count4), 32'(n_sent4));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("queue4_empty", 32'(exp_q4.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
